decrement_sequencer: RTL and testbench

- Controller that drives the 4-bit combinational decrementor datapath (o = inp - 1) as a timed countdown.
- Captures a start value, applies one decrement every STEP_CYCLES clocks, and supports pause and abort.
- Signals completion with a one-cycle done pulse.
- Sits between a host/control FSM and the decrementor instance; the host sees a simple start/busy/done handshake.

---
 rtl/dec_seq_pkg.sv | 22 ++
 rtl/decrementor.sv | 23 ++
 rtl/decrement_sequencer.sv | 131 +++++++++++++
 tb/tb_decrement_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dec_seq_pkg.sv
// Shared definitions for the decrement sequencer: state encoding, default
// count width and prescaler width.
package dec_seq_pkg;

  // Default count width; matches the decrementor datapath width.
  localparam int CNT_W_DEF = 4;

  // Largest supported STEP_CYCLES value.
  localparam int STEP_MAX = 16;

  // Prescaler width sized for STEP_MAX (5 bits for 16).
  localparam int PRESC_W = $clog2(STEP_MAX) + 1;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/decrementor.sv
// Combinational decrementor: o = inp - 1, built as a ripple-borrow chain.
// 0 wraps to all ones; the sequencer never presents 0 while stepping.
module decrementor #(
  parameter int W = 4
) (
  input  logic [W-1:0] inp,
  output logic [W-1:0] o
);

  // borrow[i] is set when every bit below i is zero.
  logic [W-1:0] borrow;

  assign borrow[0] = 1'b1;

  // Each bit flips while a borrow ripples into it.
  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign o[gi] = inp[gi] ^ borrow[gi];
    if (gi < W - 1) begin : g_chain
      assign borrow[gi+1] = borrow[gi] & ~inp[gi];
    end
  end

endmodule

// File: rtl/decrement_sequencer.sv
// Timed countdown controller around the decrementor datapath.
// Start/busy/done handshake towards the host, one decrement every
// STEP_CYCLES clocks, with pause and abort.
// Optional feature macro: DECREMENT_SEQUENCER_AUTO_RELOAD_EN -- when defined,
// a completed countdown reloads the captured start value and runs again.
module decrement_sequencer
  import dec_seq_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int STEP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] load_val,
  input  logic             pause,
  input  logic             abort,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             tick,
  output logic             done
);

  // Prescaler value on which a decrement is applied.
  localparam logic [PRESC_W-1:0] STEP_LAST = PRESC_W'(STEP_CYCLES - 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [PRESC_W-1:0] presc_reg, presc_next;
  logic               tick_reg, tick_next;
  logic [CNT_W-1:0]   dec_count;

`ifdef DECREMENT_SEQUENCER_AUTO_RELOAD_EN
  logic [CNT_W-1:0]   shadow_reg, shadow_next;
`endif

  // Single datapath instance: the next count on a step is count - 1.
  decrementor #(.W(CNT_W)) u_dec (
    .inp (count_reg),
    .o   (dec_count)
  );

  // Next-state and next-value logic; abort outranks pause, pause outranks a step.
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    presc_next  = presc_reg;
    tick_next   = 1'b0;
`ifdef DECREMENT_SEQUENCER_AUTO_RELOAD_EN
    shadow_next = shadow_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          count_next = load_val;
          presc_next = '0;
          state_next = (load_val != '0) ? RUN : DONE;
`ifdef DECREMENT_SEQUENCER_AUTO_RELOAD_EN
          shadow_next = load_val;
`endif
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (pause) begin
          state_next = PAUSE;
        end else if (presc_reg == STEP_LAST) begin
          count_next = dec_count;
          presc_next = '0;
          tick_next  = 1'b1;
          if (count_reg == CNT_W'(1)) begin
            state_next = DONE;
          end
        end else begin
          presc_next = presc_reg + 1'b1;
        end
      end
      PAUSE: begin
        // Resume keeps the frozen prescaler; the exit edge does not count.
        if (abort) begin
          state_next = IDLE;
        end else if (!pause) begin
          state_next = RUN;
        end
      end
      DONE: begin
`ifdef DECREMENT_SEQUENCER_AUTO_RELOAD_EN
        // Loop back with the captured value unless aborted or started from 0.
        if (!abort && shadow_reg != '0) begin
          state_next = RUN;
          count_next = shadow_reg;
          presc_next = '0;
        end else begin
          state_next = IDLE;
        end
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      presc_reg  <= '0;
      tick_reg   <= 1'b0;
`ifdef DECREMENT_SEQUENCER_AUTO_RELOAD_EN
      shadow_reg <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      presc_reg  <= presc_next;
      tick_reg   <= tick_next;
`ifdef DECREMENT_SEQUENCER_AUTO_RELOAD_EN
      shadow_reg <= shadow_next;
`endif
    end
  end

  assign count = count_reg;
  assign tick  = tick_reg;
  assign busy  = (state_reg == RUN) || (state_reg == PAUSE);
  assign done  = (state_reg == DONE);

endmodule

// File: tb/tb_decrement_sequencer.sv
// Randomised scoreboard bench for decrement_sequencer. Stimulus computes the
// expected tick/done events (cycle and count) from the countdown rules and
// queues them; a negedge monitor pops and compares whenever tick or done is high.
module tb_decrement_sequencer;

  localparam int S = 3;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] load_val;
  logic         pause;
  logic         abort;
  logic [W-1:0] count;
  logic         busy;
  logic         tick;
  logic         done;

  decrement_sequencer #(.CNT_W(W), .STEP_CYCLES(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .load_val (load_val),
    .pause    (pause),
    .abort    (abort),
    .count    (count),
    .busy     (busy),
    .tick     (tick),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge number X, cyc == X.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_done;
    int cnt;
    int at;
  } ev_t;

  ev_t expq[$];
  int  errors = 0;
  int  checks = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every tick/done pulse must match the next queued expectation.
  always @(negedge clk) begin
    ev_t e;
    if (tick === 1'b1) begin
      if (expq.size() == 0) begin
        chk("tick_unexpected", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("tick_kind", int'(e.is_done), 0);
        chk("tick_count", int'(count), e.cnt);
        chk("tick_cycle", cyc, e.at);
      end
    end
    if (done === 1'b1) begin
      if (expq.size() == 0) begin
        chk("done_unexpected", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("done_kind", int'(e.is_done), 1);
        chk("done_count", int'(count), 0);
        chk("done_cycle", cyc, e.at);
        chk("done_busy", int'(busy), 0);
      end
    end
  end

  // Drive pause/abort/reset/stray starts relative to capture edge e0 until
  // the DUT is expected back in IDLE at edge e0+idle_rel; then check idle.
  task automatic drive_and_check(input int e0, input int idle_rel, input int pk,
                                 input int plen, input int cut, input bit cut_rst,
                                 input bit rand_start, input int fin);
    int rel;
    for (int g = 0; g < 2000; g++) begin
      @(posedge clk);
      #1;
      rel = cyc - e0;
      if (rel >= idle_rel) break;
      start    = 1'b0;
      pause    = 1'b0;
      abort    = 1'b0;
      rst      = 1'b0;
      load_val = W'($urandom);
      if (pk >= 0 && rel >= pk * S && rel < pk * S + plen) pause = 1'b1;
      if (cut >= 0 && rel == cut - 1) begin
        if (cut_rst) rst = 1'b1;
        else begin
          abort = 1'b1;
          pause = 1'b1;
        end
      end
      if (rand_start && $urandom_range(0, 2) == 0) start = 1'b1;
    end
    start = 1'b0;
    pause = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
    chk("idle_tick", int'(tick), 0);
    chk("idle_count", int'(count), fin);
    chk("queue_drained", expq.size(), 0);
    expq.delete();
  endtask

  // One countdown of n. pk>=0: pause for plen edges after tick pk.
  // cut>=0: abort (with pause) or reset sampled at edge e0+cut.
  task automatic run_txn(input int n, input int pk, input int plen, input int cut,
                         input bit cut_rst, input bit rand_start);
    int e0, delay, t, nt, idle_rel, fin, ppk;
    ppk      = (pk >= 0 && pk < n) ? pk : -1;
    delay    = (ppk >= 0) ? plen + 1 : 0;
    load_val = W'(n);
    start    = 1'b1;
    e0       = cyc + 1;
    nt       = 0;
    for (int k = 1; k <= n; k++) begin
      t = k * S + ((ppk >= 0 && k > ppk) ? delay : 0);
      if (cut < 0 || t < cut) begin
        expq.push_back('{1'b0, n - k, e0 + t});
        nt++;
      end
    end
    if (cut < 0) begin
      expq.push_back('{1'b1, 0, e0 + n * S + delay});
      idle_rel = n * S + delay + 1;
      fin      = 0;
    end else begin
      idle_rel = cut;
      fin      = cut_rst ? 0 : n - nt;
    end
    drive_and_check(e0, idle_rel, ppk, plen, cut, cut_rst, rand_start, fin);
    $display("txn load=%0d pause_after=%0d len=%0d cut=%0d rst=%0d ticks=%0d final=%0d",
             n, ppk, plen, cut, cut_rst, nt, fin);
  endtask

`ifdef DECREMENT_SEQUENCER_AUTO_RELOAD_EN
  // Auto-reload: loops complete countdowns, then an abort after the first
  // tick of the next loop.
  task automatic run_reload(input int n, input int loops);
    int e0, len, b, cut;
    len      = n * S + 1;
    load_val = W'(n);
    start    = 1'b1;
    e0       = cyc + 1;
    for (int j = 0; j < loops; j++) begin
      b = j * len;
      for (int k = 1; k <= n; k++) expq.push_back('{1'b0, n - k, e0 + b + k * S});
      expq.push_back('{1'b1, 0, e0 + b + n * S});
    end
    b   = loops * len;
    cut = b + S + 1;
    expq.push_back('{1'b0, n - 1, e0 + b + S});
    drive_and_check(e0, cut, -1, 0, cut, 1'b0, 1'b0, n - 1);
    $display("txn reload load=%0d loops=%0d final=%0d", n, loops, n - 1);
  endtask
`endif

  initial begin
    int n, mode;
    rst      = 1'b1;
    start    = 1'b0;
    pause    = 1'b0;
    abort    = 1'b0;
    load_val = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_count", int'(count), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_tick", int'(tick), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
`ifdef DECREMENT_SEQUENCER_AUTO_RELOAD_EN
    run_txn(0, -1, 0, -1, 1'b0, 1'b0);
    run_reload(3, 3);
    run_txn(8, -1, 0, 5 * S + 1, 1'b0, 1'b0);
    run_txn(9, -1, 0, 5, 1'b1, 1'b0);
`else
    run_txn(5, -1, 0, -1, 1'b0, 1'b0);          // plain countdown
    run_txn(2, -1, 0, -1, 1'b0, 1'b1);          // starts during RUN/DONE ignored
    run_txn(0, -1, 0, -1, 1'b0, 1'b1);          // zero load: done, no ticks
    run_txn(8, 2, 4, -1, 1'b0, 1'b0);           // pause after 2nd tick
    run_txn(8, -1, 0, 5 * S + 1, 1'b0, 1'b0);   // abort+pause at count 3
    run_txn(4, -1, 0, 4 * S, 1'b0, 1'b0);       // abort on terminal edge
    run_txn(9, -1, 0, 5, 1'b1, 1'b0);           // reset mid-run
    run_txn(15, -1, 0, -1, 1'b0, 1'b0);         // maximum load
    for (int i = 0; i < 12; i++) begin
      n    = $urandom_range(0, 15);
      mode = $urandom_range(0, 2);
      if (mode == 1 && n >= 2)
        run_txn(n, $urandom_range(1, n - 1), $urandom_range(1, 5), -1, 1'b0, 1'b1);
      else if (mode == 2 && n >= 1)
        run_txn(n, -1, 0, $urandom_range(1, n * S), 1'b0, 1'b1);
      else
        run_txn(n, -1, 0, -1, 1'b0, 1'b1);
    end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
